// File: rtl/mem_port_arbiter_if.sv
// rtl/mem_port_arbiter_if.sv - bus bundle between the CPU ports, the arbiter and physical memory
//
// Purpose: groups the two CPU request ports (A = instruction fetch,
// B = data access) and the single physical memory port into one bundle.
// Modports:
//   slave  - arbiter view: takes CPU requests and pmem_resp/pmem_rdata,
//            drives resp_x/rdata_x and the pmem_* request.
//   master - environment view: the CPU ports and the memory device.
// Signals per CPU port x in {a,b}:
//   read_x, write_x (1), wmask_x (2), address_x (16), wdata_x (16)  -> arbiter
//   resp_x (1), rdata_x (16)                                        <- arbiter
// Physical memory:
//   pmem_read, pmem_write (1), pmem_wmask (2), pmem_address (16),
//   pmem_wdata (16)                                                 <- arbiter
//   pmem_resp (1), pmem_rdata (16)                                  -> arbiter
interface mem_port_arbiter_if;
  logic        read_a;
  logic        write_a;
  logic [1:0]  wmask_a;
  logic [15:0] address_a;
  logic [15:0] wdata_a;
  logic        resp_a;
  logic [15:0] rdata_a;

  logic        read_b;
  logic        write_b;
  logic [1:0]  wmask_b;
  logic [15:0] address_b;
  logic [15:0] wdata_b;
  logic        resp_b;
  logic [15:0] rdata_b;

  logic        pmem_read;
  logic        pmem_write;
  logic [1:0]  pmem_wmask;
  logic [15:0] pmem_address;
  logic [15:0] pmem_wdata;
  logic        pmem_resp;
  logic [15:0] pmem_rdata;

  modport slave (
    input  read_a, write_a, wmask_a, address_a, wdata_a,
    output resp_a, rdata_a,
    input  read_b, write_b, wmask_b, address_b, wdata_b,
    output resp_b, rdata_b,
    output pmem_read, pmem_write, pmem_wmask, pmem_address, pmem_wdata,
    input  pmem_resp, pmem_rdata
  );

  modport master (
    output read_a, write_a, wmask_a, address_a, wdata_a,
    input  resp_a, rdata_a,
    output read_b, write_b, wmask_b, address_b, wdata_b,
    input  resp_b, rdata_b,
    input  pmem_read, pmem_write, pmem_wmask, pmem_address, pmem_wdata,
    output pmem_resp, pmem_rdata
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - round-robin two-port to one-port memory arbiter
//
// Purpose: serialises 16-bit read/write requests from CPU port A and port B
// onto one physical memory port, one outstanding transaction at a time,
// and returns a one-cycle resp pulse plus read data to the winning port.
// Ports:
//   clk   - system clock, rising edge
//   reset - synchronous, active-high
//   bus   - mem_port_arbiter_if.slave (CPU ports A/B and physical memory)
module mem_port_arbiter (
  input  logic                  clk,
  input  logic                  reset,
  mem_port_arbiter_if.slave     bus
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    SERVE_A = 3'd1,
    SERVE_B = 3'd2,
    DONE_A  = 3'd3,
    DONE_B  = 3'd4
  } state_t;

  state_t      r_state;
  state_t      w_next_state;

  // r_last_b = 1 means the most recent grant went to port B
  logic        r_last_b;
  logic        r_pmem_read;
  logic        r_pmem_write;
  logic [1:0]  r_pmem_wmask;
  logic [15:0] r_pmem_address;
  logic [15:0] r_pmem_wdata;
  logic [15:0] r_rdata;

  logic        w_req_a;
  logic        w_req_b;
  logic        w_grant_a;
  logic        w_grant_b;
  logic        w_serving;

  logic        w_nxt_last_b;
  logic        w_nxt_pmem_read;
  logic        w_nxt_pmem_write;
  logic [1:0]  w_nxt_pmem_wmask;
  logic [15:0] w_nxt_pmem_address;
  logic [15:0] w_nxt_pmem_wdata;
  logic [15:0] w_nxt_rdata;
  logic        w_resp_a;
  logic        w_resp_b;

  assign w_req_a   = bus.read_a | bus.write_a;
  assign w_req_b   = bus.read_b | bus.write_b;
  assign w_serving = (r_state == SERVE_A) || (r_state == SERVE_B);

  // Grants are only ever issued from IDLE; on a tie the port that did not
  // win last time goes next.
  always_comb begin
    w_grant_a = 1'b0;
    w_grant_b = 1'b0;
    if (r_state == IDLE) begin
      if (w_req_a && w_req_b) begin
        w_grant_a = r_last_b;
        w_grant_b = !r_last_b;
      end else begin
        w_grant_a = w_req_a;
        w_grant_b = w_req_b;
      end
    end
  end

  // State register
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Next-state logic
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      IDLE: begin
        if (w_grant_a) begin
          w_next_state = SERVE_A;
        end else if (w_grant_b) begin
          w_next_state = SERVE_B;
        end
      end
      SERVE_A: if (bus.pmem_resp) w_next_state = DONE_A;
      SERVE_B: if (bus.pmem_resp) w_next_state = DONE_B;
      DONE_A:  w_next_state = IDLE;
      DONE_B:  w_next_state = IDLE;
      default: w_next_state = IDLE;
    endcase
  end

  // Output logic: next values for the registered pmem/rdata outputs and
  // the resp pulses decoded from the DONE states.
  always_comb begin
    w_nxt_last_b       = r_last_b;
    w_nxt_pmem_read    = r_pmem_read;
    w_nxt_pmem_write   = r_pmem_write;
    w_nxt_pmem_wmask   = r_pmem_wmask;
    w_nxt_pmem_address = r_pmem_address;
    w_nxt_pmem_wdata   = r_pmem_wdata;
    w_nxt_rdata        = r_rdata;

    // read+write together is resolved as a write
    if (w_grant_a) begin
      w_nxt_last_b       = 1'b0;
      w_nxt_pmem_read    = bus.read_a & ~bus.write_a;
      w_nxt_pmem_write   = bus.write_a;
      w_nxt_pmem_wmask   = bus.wmask_a;
      w_nxt_pmem_address = bus.address_a;
      w_nxt_pmem_wdata   = bus.wdata_a;
    end else if (w_grant_b) begin
      w_nxt_last_b       = 1'b1;
      w_nxt_pmem_read    = bus.read_b & ~bus.write_b;
      w_nxt_pmem_write   = bus.write_b;
      w_nxt_pmem_wmask   = bus.wmask_b;
      w_nxt_pmem_address = bus.address_b;
      w_nxt_pmem_wdata   = bus.wdata_b;
    end

    if (w_serving && bus.pmem_resp) begin
      w_nxt_pmem_read  = 1'b0;
      w_nxt_pmem_write = 1'b0;
      if (r_pmem_read) begin
        w_nxt_rdata = bus.pmem_rdata;
      end
    end

    w_resp_a = (r_state == DONE_A);
    w_resp_b = (r_state == DONE_B);
  end

  // Datapath registers
  always_ff @(posedge clk) begin
    if (reset) begin
      r_last_b       <= 1'b1;
      r_pmem_read    <= 1'b0;
      r_pmem_write   <= 1'b0;
      r_pmem_wmask   <= 2'b00;
      r_pmem_address <= 16'h0000;
      r_pmem_wdata   <= 16'h0000;
      r_rdata        <= 16'h0000;
    end else begin
      r_last_b       <= w_nxt_last_b;
      r_pmem_read    <= w_nxt_pmem_read;
      r_pmem_write   <= w_nxt_pmem_write;
      r_pmem_wmask   <= w_nxt_pmem_wmask;
      r_pmem_address <= w_nxt_pmem_address;
      r_pmem_wdata   <= w_nxt_pmem_wdata;
      r_rdata        <= w_nxt_rdata;
    end
  end

  assign bus.pmem_read    = r_pmem_read;
  assign bus.pmem_write   = r_pmem_write;
  assign bus.pmem_wmask   = r_pmem_wmask;
  assign bus.pmem_address = r_pmem_address;
  assign bus.pmem_wdata   = r_pmem_wdata;
  assign bus.resp_a       = w_resp_a;
  assign bus.resp_b       = w_resp_b;
  assign bus.rdata_a      = r_rdata;
  assign bus.rdata_b      = r_rdata;

endmodule
